sigma_bus_arb2: RTL and testbench

SIGMA_BUS_ARB2 -- requirements
Module: sigma_bus_arb2

---
 rtl/sigma_bus_arb2.sv | 114 +++++++++++
 tb/tb_sigma_bus_arb2.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sigma_bus_arb2.sv
// sigma_bus_arb2: two-master, single-slave bus arbiter with a read-response timeout
module sigma_bus_arb2 #(
    parameter int          RR_EN        = 1,
    parameter int          RESP_TIMEOUT = 64,
    parameter logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        m0_req_i,
    input  logic        m0_we_i,
    input  logic [31:0] m0_addr_i,
    input  logic [3:0]  m0_be_i,
    input  logic [31:0] m0_wdata_i,
    output logic        m0_ack_o,
    output logic        m0_resp_o,
    output logic [31:0] m0_rdata_o,
    input  logic        m1_req_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_addr_i,
    input  logic [3:0]  m1_be_i,
    input  logic [31:0] m1_wdata_i,
    output logic        m1_ack_o,
    output logic        m1_resp_o,
    output logic [31:0] m1_rdata_o,
    output logic        s_req_o,
    output logic        s_we_o,
    output logic [31:0] s_addr_o,
    output logic [3:0]  s_be_o,
    output logic [31:0] s_wdata_o,
    input  logic        s_ack_i,
    input  logic        s_resp_i,
    input  logic [31:0] s_rdata_i,
    output logic [1:0]  grant_o,
    output logic        busy_o,
    output logic        tmo_err_o
);
    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] GRANT     = 2'd1;
    localparam logic [1:0] WAIT_RESP = 2'd2;
    logic [1:0]  state;
    logic [15:0] cnt;
    logic        last;
    logic        win;
    logic        own;
    logic        in_g;
    logic        in_w;
    logic        tmo_hit;
    logic        o_req;
    logic        o_we;
    logic [31:0] o_addr;
    logic [3:0]  o_be;
    logic [31:0] o_wdata;
    logic [31:0] rdata;
    // last = 1 means m1 owned the bus most recently, so m0 wins the next tie
    assign win     = (m0_req_i && m1_req_i) ? ((RR_EN != 0) ? !last : 1'b1) : m1_req_i;
    assign own     = grant_o[1];
    assign in_g    = state == GRANT;
    assign in_w    = state == WAIT_RESP;
    assign o_req   = own ? m1_req_i : m0_req_i;
    assign o_we    = own ? m1_we_i : m0_we_i;
    assign o_addr  = own ? m1_addr_i : m0_addr_i;
    assign o_be    = own ? m1_be_i : m0_be_i;
    assign o_wdata = own ? m1_wdata_i : m0_wdata_i;
    assign tmo_hit = in_w && !s_resp_i && cnt == 16'(RESP_TIMEOUT - 1);
    assign rdata   = tmo_hit ? TIMEOUT_DATA : s_rdata_i;
    assign s_req_o    = in_g && o_req;
    assign s_we_o     = in_g && o_we;
    assign s_addr_o   = in_g ? o_addr : '0;
    assign s_be_o     = in_g ? o_be : '0;
    assign s_wdata_o  = in_g ? o_wdata : '0;
    assign m0_ack_o   = in_g && grant_o[0] && s_ack_i;
    assign m1_ack_o   = in_g && grant_o[1] && s_ack_i;
    assign m0_resp_o  = in_w && grant_o[0] && (s_resp_i || tmo_hit);
    assign m1_resp_o  = in_w && grant_o[1] && (s_resp_i || tmo_hit);
    assign m0_rdata_o = (in_w && grant_o[0]) ? rdata : '0;
    assign m1_rdata_o = (in_w && grant_o[1]) ? rdata : '0;
    assign busy_o     = state != IDLE;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            grant_o   <= '0;
            tmo_err_o <= 1'b0;
            cnt       <= '0;
            last      <= 1'b1;
        end else begin
            case (state)
                IDLE: if (m0_req_i || m1_req_i) begin
                    state   <= GRANT;
                    grant_o <= win ? 2'b10 : 2'b01;
                    last    <= win;
                end
                GRANT: if (!o_req) begin
                    state   <= IDLE;
                    grant_o <= '0;
                end else if (s_ack_i) begin
                    state   <= o_we ? IDLE : WAIT_RESP;
                    grant_o <= o_we ? 2'b00 : grant_o;
                    cnt     <= '0;
                end
                WAIT_RESP: if (s_resp_i || tmo_hit) begin
                    state     <= IDLE;
                    grant_o   <= '0;
                    tmo_err_o <= tmo_err_o || tmo_hit;
                end else begin
                    cnt <= cnt + 16'd1;
                end
                default: begin
                    state   <= IDLE;
                    grant_o <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sigma_bus_arb2.sv
// tb_sigma_bus_arb2: directed and random checks of a round-robin and a fixed-priority arbiter
module tb_sigma_bus_arb2;
    localparam int TMO = 8;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
    logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
    logic [3:0]  m0_be = '0, m1_be = '0;
    logic        s_ack = 1'b0, s_resp = 1'b0;
    logic [31:0] s_rdata = '0;
    logic        m0_ack[2], m0_resp[2], m1_ack[2], m1_resp[2];
    logic        s_req[2], s_we[2], busy[2], tmo_err[2];
    logic [31:0] m0_rdata[2], m1_rdata[2], s_addr[2], s_wdata[2];
    logic [3:0]  s_be[2];
    logic [1:0]  grant[2];
    int checks = 0;
    int failures = 0;
    int ph[2], own[2], lastm[2], waited[2];
    bit sticky[2];
    always #5 clk = ~clk;
    sigma_bus_arb2 #(.RR_EN(1), .RESP_TIMEOUT(TMO)) dut_rr (
        .clk_i(clk), .rst_i(rst),
        .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_be_i(m0_be), .m0_wdata_i(m0_wdata),
        .m0_ack_o(m0_ack[0]), .m0_resp_o(m0_resp[0]), .m0_rdata_o(m0_rdata[0]),
        .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_be_i(m1_be), .m1_wdata_i(m1_wdata),
        .m1_ack_o(m1_ack[0]), .m1_resp_o(m1_resp[0]), .m1_rdata_o(m1_rdata[0]),
        .s_req_o(s_req[0]), .s_we_o(s_we[0]), .s_addr_o(s_addr[0]), .s_be_o(s_be[0]), .s_wdata_o(s_wdata[0]),
        .s_ack_i(s_ack), .s_resp_i(s_resp), .s_rdata_i(s_rdata),
        .grant_o(grant[0]), .busy_o(busy[0]), .tmo_err_o(tmo_err[0])
    );
    sigma_bus_arb2 #(.RR_EN(0), .RESP_TIMEOUT(TMO)) dut_fp (
        .clk_i(clk), .rst_i(rst),
        .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_be_i(m0_be), .m0_wdata_i(m0_wdata),
        .m0_ack_o(m0_ack[1]), .m0_resp_o(m0_resp[1]), .m0_rdata_o(m0_rdata[1]),
        .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_be_i(m1_be), .m1_wdata_i(m1_wdata),
        .m1_ack_o(m1_ack[1]), .m1_resp_o(m1_resp[1]), .m1_rdata_o(m1_rdata[1]),
        .s_req_o(s_req[1]), .s_we_o(s_we[1]), .s_addr_o(s_addr[1]), .s_be_o(s_be[1]), .s_wdata_o(s_wdata[1]),
        .s_ack_i(s_ack), .s_resp_i(s_resp), .s_rdata_i(s_rdata),
        .grant_o(grant[1]), .busy_o(busy[1]), .tmo_err_o(tmo_err[1])
    );
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    // model: ph 0 = bus free, 1 = owner presenting its request, 2 = owner awaiting read data
    task automatic model_check();
        for (int i = 0; i < 2; i++) begin
            logic oreq, owe, tout;
            logic [31:0] oaddr, owd, rd;
            logic [3:0] obe;
            oreq  = own[i] == 1 ? m1_req : m0_req;
            owe   = own[i] == 1 ? m1_we : m0_we;
            oaddr = own[i] == 1 ? m1_addr : m0_addr;
            owd   = own[i] == 1 ? m1_wdata : m0_wdata;
            obe   = own[i] == 1 ? m1_be : m0_be;
            tout  = ph[i] == 2 && !s_resp && waited[i] == TMO - 1;
            rd    = tout ? 32'hDEADBEEF : s_rdata;
            chk($sformatf("grant[%0d]", i), 32'(grant[i]), ph[i] == 0 ? 32'd0 : 32'(1 << own[i]));
            chk($sformatf("busy[%0d]", i), 32'(busy[i]), 32'(ph[i] != 0));
            chk($sformatf("tmo_err[%0d]", i), 32'(tmo_err[i]), 32'(sticky[i]));
            chk($sformatf("s_req[%0d]", i), 32'(s_req[i]), 32'(ph[i] == 1 && oreq));
            chk($sformatf("s_we[%0d]", i), 32'(s_we[i]), 32'(ph[i] == 1 && owe));
            chk($sformatf("s_addr[%0d]", i), s_addr[i], ph[i] == 1 ? oaddr : 32'd0);
            chk($sformatf("s_be[%0d]", i), 32'(s_be[i]), ph[i] == 1 ? 32'(obe) : 32'd0);
            chk($sformatf("s_wdata[%0d]", i), s_wdata[i], ph[i] == 1 ? owd : 32'd0);
            chk($sformatf("m0_ack[%0d]", i), 32'(m0_ack[i]), 32'(ph[i] == 1 && own[i] == 0 && s_ack));
            chk($sformatf("m1_ack[%0d]", i), 32'(m1_ack[i]), 32'(ph[i] == 1 && own[i] == 1 && s_ack));
            chk($sformatf("m0_resp[%0d]", i), 32'(m0_resp[i]), 32'(ph[i] == 2 && own[i] == 0 && (s_resp || tout)));
            chk($sformatf("m1_resp[%0d]", i), 32'(m1_resp[i]), 32'(ph[i] == 2 && own[i] == 1 && (s_resp || tout)));
            chk($sformatf("m0_rdata[%0d]", i), m0_rdata[i], (ph[i] == 2 && own[i] == 0) ? rd : 32'd0);
            chk($sformatf("m1_rdata[%0d]", i), m1_rdata[i], (ph[i] == 2 && own[i] == 1) ? rd : 32'd0);
        end
    endtask
    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            logic oreq, owe, tout;
            int w;
            oreq = own[i] == 1 ? m1_req : m0_req;
            owe  = own[i] == 1 ? m1_we : m0_we;
            tout = ph[i] == 2 && !s_resp && waited[i] == TMO - 1;
            if (rst) begin
                ph[i] = 0; lastm[i] = 1; waited[i] = 0; sticky[i] = 0;
            end else if (ph[i] == 0) begin
                if (m0_req || m1_req) begin
                    w = (m0_req && m1_req) ? (i == 0 ? 1 - lastm[i] : 1) : (m1_req ? 1 : 0);
                    own[i] = w; lastm[i] = w; ph[i] = 1;
                end
            end else if (ph[i] == 1) begin
                if (!oreq) ph[i] = 0;
                else if (s_ack) begin ph[i] = owe ? 0 : 2; waited[i] = 0; end
            end else if (s_resp || tout) begin
                ph[i] = 0; sticky[i] = sticky[i] | tout;
            end else begin
                waited[i]++;
            end
        end
    endtask
    task automatic settle();
        @(negedge clk);
        model_check();
    endtask
    task automatic adv();
        @(posedge clk);
        model_step();
        #1;
    endtask
    task automatic cyc();
        settle();
        adv();
    endtask
    task automatic quiet();
        m0_req = 0; m1_req = 0; m0_we = 0; m1_we = 0; s_ack = 0; s_resp = 0;
    endtask
    task automatic do_reset();
        quiet();
        rst = 1;
        cyc();
        rst = 0;
    endtask
    task automatic start_read(input bit m, input logic [31:0] a);
        if (m) begin m1_req = 1; m1_we = 0; m1_addr = a; end
        else begin m0_req = 1; m0_we = 0; m0_addr = a; end
        cyc();
        s_ack = 1;
        cyc();
        quiet();
    endtask
    initial begin
        for (int i = 0; i < 2; i++) begin ph[i] = 0; own[i] = 0; lastm[i] = 1; waited[i] = 0; sticky[i] = 0; end
        adv();
        rst = 0;
        settle();
        chk("rst_grant", 32'(grant[0]), 32'd0);
        chk("rst_busy", 32'(busy[0]), 32'd0);
        adv();
        // single write from m0, slave acks in the first GRANT cycle
        m0_req = 1; m0_we = 1; m0_addr = 32'h80000000; m0_wdata = 32'hDEADBEEF; m0_be = 4'hF;
        settle();
        chk("wr_idle_sreq", 32'(s_req[0]), 32'd0);
        adv();
        s_ack = 1;
        settle();
        chk("wr_grant", 32'(grant[0]), 32'd1);
        chk("wr_swe", 32'(s_we[0]), 32'd1);
        chk("wr_addr", s_addr[0], 32'h80000000);
        chk("wr_wdata", s_wdata[0], 32'hDEADBEEF);
        chk("wr_ack", 32'(m0_ack[0]), 32'd1);
        adv();
        quiet();
        settle();
        chk("wr_done_busy", 32'(busy[0]), 32'd0);
        chk("wr_done_ack", 32'(m0_ack[0]), 32'd0);
        adv();
        // both masters reading back to back; s_resp held high also hits IDLE/GRANT and must be dropped
        do_reset();
        m0_req = 1; m1_req = 1; s_ack = 1; s_resp = 1;
        for (int k = 0; k < 4; k++) begin
            s_rdata = 32'h1000 + 32'(k);
            cyc();
            settle();
            chk($sformatf("rr_grant%0d", k), 32'(grant[0]), k % 2 == 0 ? 32'd1 : 32'd2);
            chk($sformatf("fp_grant%0d", k), 32'(grant[1]), 32'd2);
            adv();
            settle();
            chk($sformatf("rr_resp%0d", k), 32'(k % 2 == 0 ? m0_resp[0] : m1_resp[0]), 32'd1);
            adv();
        end
        // m1 read, response on the fifth waiting cycle
        quiet();
        cyc();
        start_read(1'b1, 32'h80000004);
        for (int k = 0; k < 4; k++) cyc();
        s_resp = 1; s_rdata = 32'h00000030;
        settle();
        chk("rd_m1_resp", 32'(m1_resp[0]), 32'd1);
        chk("rd_m1_rdata", m1_rdata[0], 32'h30);
        chk("rd_m0_resp", 32'(m0_resp[0]), 32'd0);
        chk("rd_m0_rdata", m0_rdata[0], 32'd0);
        adv();
        quiet();
        // timeout on the eighth waiting cycle, later response ignored
        start_read(1'b0, 32'h80000008);
        for (int k = 0; k < TMO - 1; k++) begin
            settle();
            chk($sformatf("tmo_wait%0d", k), 32'(m0_resp[0]), 32'd0);
            adv();
        end
        settle();
        chk("tmo_resp", 32'(m0_resp[0]), 32'd1);
        chk("tmo_rdata", m0_rdata[0], 32'hDEADBEEF);
        adv();
        s_resp = 1; s_rdata = 32'h55;
        settle();
        chk("tmo_sticky", 32'(tmo_err[0]), 32'd1);
        chk("tmo_late_resp", 32'(m0_resp[0]), 32'd0);
        chk("tmo_late_rdata", m0_rdata[0], 32'd0);
        adv();
        // response coinciding with the timeout cycle wins
        do_reset();
        start_read(1'b0, 32'h8000000C);
        for (int k = 0; k < TMO - 1; k++) cyc();
        s_resp = 1; s_rdata = 32'h29;
        settle();
        chk("tie_rdata", m0_rdata[0], 32'h29);
        adv();
        quiet();
        settle();
        chk("tie_no_err", 32'(tmo_err[0]), 32'd0);
        adv();
        // reset while awaiting read data
        start_read(1'b1, 32'h80000010);
        cyc();
        rst = 1;
        cyc();
        rst = 0; s_resp = 1; s_rdata = 32'h77;
        settle();
        chk("rst_mid_busy", 32'(busy[0]), 32'd0);
        chk("rst_mid_grant", 32'(grant[0]), 32'd0);
        chk("rst_mid_resp", 32'(m1_resp[0]), 32'd0);
        chk("rst_mid_rdata", m1_rdata[0], 32'd0);
        adv();
        quiet();
        for (int n = 0; n < 3000; n++) begin
            rst      = $urandom_range(199) == 0;
            m0_req   = $urandom_range(9) < 7;
            m1_req   = $urandom_range(9) < 7;
            m0_we    = 1'($urandom_range(1));
            m1_we    = 1'($urandom_range(1));
            m0_addr  = $urandom;
            m1_addr  = $urandom;
            m0_wdata = $urandom;
            m1_wdata = $urandom;
            m0_be    = 4'($urandom);
            m1_be    = 4'($urandom);
            s_ack    = 1'($urandom_range(1));
            s_resp   = $urandom_range(4) == 0;
            s_rdata  = $urandom;
            cyc();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
